asrv32_prefetch_fetch: RTL and testbench
========================================

Name: asrv32_prefetch_fetch

Overview:
Parametrised successor to the single-entry fetch stage. It issues pipelined Wishbone instruction reads with up to MAX_OUTSTANDING requests in flight and buffers the returned words with their PCs in a FIFO_DEPTH-entry prefetch queue. It feeds the IF/ID register, using the existing pipeline stall, flush and PC-redirect interface. On a redirect it drops the queue and discards stale in-flight responses.

Parameters:
PC_RESET, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 4, prefetch queue entries; power of 2, >=2
MAX_OUTSTANDING, 2, max un-acked requests; 1..FIFO_DEPTH

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst_n  in  1  reset; one clock, synchronous, active-low
o_stb_inst  out  1  request strobe; each cycle high = one issued read
o_inst_addr  out  32  fetch address; bits [1:0] always 0
i_inst  in  32  read data, valid with ack
i_ack_inst  in  1  in-order response; at most one per cycle
o_inst_ifid  out  32  instruction to IF/ID
o_pc_ifid  out  32  PC of o_inst_ifid
i_writeback_change_pc  in  1  trap redirect; highest priority
i_writeback_next_pc  in  32  trap target
i_alu_change_pc  in  1  branch/jump redirect
i_alu_next_pc  in  32  branch/jump target
o_ce  out  1  o_inst_ifid/o_pc_ifid valid for the next stage
i_stall  in  1  downstream stall; hold outputs
i_flush  in  1  kill the current output

Behaviour:
- Reset: o_ce=0, o_inst_ifid=0, o_pc_ifid=0, fetch_pc=PC_RESET, queue empty, outstanding=0, discard=0.
  - o_stb_inst is 0 during reset and in the first cycle after release.
  - The bus slave is reset together with this block; requests issued before reset are abandoned.
- Counters: outstanding, discard and queue count are $clog2(FIFO_DEPTH)+1 bits.
- Issue: o_stb_inst = !redirect && outstanding<MAX_OUTSTANDING && (outstanding+count)<FIFO_DEPTH.
  - redirect = i_writeback_change_pc | i_alu_change_pc.
  - The slave accepts every strobe; there is no slave-side stall.
  - Each issue increments fetch_pc by 4 (wraps mod 2^32).
  - o_inst_addr = fetch_pc with bits [1:0] forced to 0.
- Response: each ack decrements outstanding.
  - If discard>0: drop the data and decrement discard.
  - Otherwise push {rsp_pc, i_inst} and add 4 to rsp_pc.
  - rsp_pc tracks the PC of the next expected response.
- Output, when !i_stall:
  - Queue non-empty: pop the head into o_inst_ifid/o_pc_ifid and set o_ce=1.
  - Queue empty with a valid (non-discarded) ack: bypass i_inst/rsp_pc straight to the outputs with o_ce=1; nothing is written to the queue.
  - Otherwise: o_ce=0.
  - Ack-to-o_ce latency is 1 cycle on bypass.
- i_stall=1: o_ce, o_inst_ifid and o_pc_ifid hold; no pop; issue and push continue while space permits.
- i_flush && !i_stall: o_ce=0 and no pop that cycle. The queue is kept (the caller pairs i_flush with a redirect when needed).
- Redirect, taking effect on the edge at the end of that cycle:
  - Target = i_writeback_next_pc if i_writeback_change_pc, else i_alu_next_pc; bits [1:0] cleared.
  - fetch_pc and rsp_pc are set to the target; the queue is emptied.
  - discard = outstanding minus 1 if an ack arrives this cycle, else outstanding. Any ack in the redirect cycle is dropped.
  - No issue in the redirect cycle.
  - If !i_stall: o_ce=0. If i_stall: the outputs hold, and o_ce is forced to 0 on the first non-stalled cycle.
- Boundaries:
  - Queue full or outstanding at limit: stb=0.
  - Push and pop in the same cycle: count unchanged.
  - Ack with outstanding=0: ignored, counters saturate at 0.
  - A second redirect while discard>0: discard recomputed from the current outstanding.
  - Simultaneous writeback and ALU redirect: writeback wins.

Test Plan:
- Reset release, ack every cycle, no stall -> addresses 0,4,8,...; o_ce=1 from cycle 3 with o_pc_ifid 0,4,8 in order.
- i_stall high for 6 cycles, MAX_OUTSTANDING=2, FIFO_DEPTH=4 -> outputs frozen; stb drops once outstanding+count=4; after release PCs resume gap-free.
- ALU redirect to 0x100 with 2 outstanding -> next 2 acks dropped; first o_pc_ifid after redirect = 0x100; o_ce=0 for the gap.
- Writeback 0x80 and ALU 0x200 in the same cycle, plus an ack that cycle -> target 0x80, ack dropped, discard = outstanding-1.
- Ack delay of 3 cycles, queue empty -> bypass: o_ce rises the cycle after each ack with the correct PC.
- Reset asserted mid-stream with a full queue -> next cycle o_ce=0, queue empty; fetch restarts at PC_RESET.

Source files
------------

// File: rtl/asrv32_prefetch_fetch_if.sv
// Instruction-fetch bus between the prefetch stage (master) and instruction memory (slave).
// Request/response rule: every cycle o_stb_inst is high, the slave accepts one read of o_inst_addr
// (no backpressure); responses return strictly in order, one i_ack_inst pulse per read, data on i_inst.
interface asrv32_prefetch_fetch_if;
  logic        o_stb_inst;
  logic [31:0] o_inst_addr;
  logic [31:0] i_inst;
  logic        i_ack_inst;

  modport master (
    output o_stb_inst,
    output o_inst_addr,
    input  i_inst,
    input  i_ack_inst
  );

  modport slave (
    input  o_stb_inst,
    input  o_inst_addr,
    output i_inst,
    output i_ack_inst
  );
endinterface

// File: rtl/asrv32_prefetch_fetch.sv
// Prefetching fetch stage: pipelined instruction reads, a small PC-tagged prefetch queue,
// and redirect handling that drops the queue and discards stale in-flight responses.
module asrv32_prefetch_fetch #(
  parameter logic [31:0] PC_RESET        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  asrv32_prefetch_fetch_if.master        bus,
  output logic [31:0]                    o_inst_ifid,
  output logic [31:0]                    o_pc_ifid,
  input  logic                           i_writeback_change_pc,
  input  logic [31:0]                    i_writeback_next_pc,
  input  logic                           i_alu_change_pc,
  input  logic [31:0]                    i_alu_next_pc,
  output logic                           o_ce,
  input  logic                           i_stall,
  input  logic                           i_flush
);
  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]     PC_BASE = {PC_RESET[31:2], 2'b00};

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [63:0]   mem [FIFO_DEPTH];
  logic          run_q;
  logic          kill_q;

  logic          redirect;
  logic [31:0]   target;
  logic [CW:0]   in_use;
  logic          issue;
  logic          ack_ok;
  logic          ack_keep;
  logic          out_free;
  logic          pop;
  logic          bypass;
  logic          push;

  always_comb begin
    redirect = i_writeback_change_pc | i_alu_change_pc;
    target   = i_writeback_change_pc ? i_writeback_next_pc : i_alu_next_pc;
    target[1:0] = 2'b00;
    // Space is reserved for every in-flight read, so an arriving response always fits.
    in_use   = {1'b0, outstanding} + {1'b0, count};
    issue    = i_rst_n && run_q && !redirect && (outstanding < MAX_C) && (in_use < DEPTH_W);
    ack_ok   = bus.i_ack_inst && (outstanding != '0);
    ack_keep = ack_ok && !redirect && (discard == '0);
    out_free = !i_stall && !i_flush && !kill_q && !redirect;
    pop      = out_free && (count != '0);
    bypass   = out_free && (count == '0) && ack_keep;
    push     = ack_keep && !bypass && (count < DEPTH_C);
  end

  assign bus.o_stb_inst  = issue;
  assign bus.o_inst_addr = fetch_pc;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {rsp_pc, bus.i_inst};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc    <= PC_BASE;
      rsp_pc      <= PC_BASE;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      run_q       <= 1'b0;
      kill_q      <= 1'b0;
      o_ce        <= 1'b0;
      o_inst_ifid <= '0;
      o_pc_ifid   <= '0;
    end else begin
      run_q       <= 1'b1;
      outstanding <= outstanding + CW'(issue) - CW'(ack_ok);
      if (redirect) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        discard  <= outstanding - CW'(ack_ok);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (ack_ok && (discard != '0)) discard <= discard - CW'(1);
        if (ack_keep) rsp_pc <= rsp_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      // A redirect seen under stall leaves a wrong-path word on the outputs; kill it once the stall lifts.
      if (!i_stall) begin
        kill_q <= 1'b0;
        o_ce   <= pop | bypass;
        if (pop) begin
          {o_pc_ifid, o_inst_ifid} <= mem[rd_ptr];
        end else if (bypass) begin
          o_pc_ifid   <= rsp_pc;
          o_inst_ifid <= bus.i_inst;
        end
      end else if (redirect) begin
        kill_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_asrv32_prefetch_fetch.sv
// Bench for asrv32_prefetch_fetch: in-order memory model, stream-level reference, directed and random runs.
module tb_asrv32_prefetch_fetch;
  localparam logic [31:0] PC_RESET        = 32'h0000_0000;
  localparam int          FIFO_DEPTH      = 4;
  localparam int          MAX_OUTSTANDING = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] o_inst_ifid;
  logic [31:0] o_pc_ifid;
  logic        i_writeback_change_pc = 1'b0;
  logic [31:0] i_writeback_next_pc = '0;
  logic        i_alu_change_pc = 1'b0;
  logic [31:0] i_alu_next_pc = '0;
  logic        o_ce;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;

  asrv32_prefetch_fetch_if bus();

  asrv32_prefetch_fetch #(
    .PC_RESET(PC_RESET), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_inst_ifid(o_inst_ifid), .o_pc_ifid(o_pc_ifid),
    .i_writeback_change_pc(i_writeback_change_pc), .i_writeback_next_pc(i_writeback_next_pc),
    .i_alu_change_pc(i_alu_change_pc), .i_alu_next_pc(i_alu_next_pc),
    .o_ce(o_ce), .i_stall(i_stall), .i_flush(i_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wb;
    logic [31:0] wb_pc;
    bit          alu;
    logic [31:0] alu_pc;
    bit          ack;
    bit          dbl;
    logic [31:0] exp_pc;
    int          exp_gap;
  } redir_vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  int          cyc = 0;
  int          ack_delay = 1;
  bit          spur = 1'b0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_deliver;
  bit          stale = 1'b0;
  bit          prev_stall = 1'b0;
  logic        prev_ce;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  int          delivered = 0;
  bit          last_ack;
  logic        last_stb;
  logic [31:0] last_addr;
  logic        last_ce;
  logic [31:0] last_pc;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0; spur = 1'b0;
    i_writeback_change_pc = 1'b0; i_alu_change_pc = 1'b0;
    bus.i_ack_inst = 1'b0; bus.i_inst = '0;
    @(negedge clk);
    chk("reset_stb", 32'(bus.o_stb_inst), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
    pend_addr.delete(); pend_cyc.delete();
    exp_fetch = PC_RESET; exp_deliver = PC_RESET;
    stale = 1'b0; prev_stall = 1'b0;
    @(negedge clk);
    chk("reset_ce", 32'(o_ce), 32'd0);
    chk("reset_pc", o_pc_ifid, 32'd0);
    chk("reset_inst", o_inst_ifid, 32'd0);
    chk("release_stb", 32'(bus.o_stb_inst), 32'd0);
  endtask

  task automatic step(input bit stall, input bit flush, input bit wb, input logic [31:0] wb_pc,
                      input bit alu, input logic [31:0] alu_pc, input bit ack_en);
    logic [31:0] tgt;
    @(posedge clk); #1;
    cyc++;
    i_stall = stall; i_flush = flush;
    i_writeback_change_pc = wb; i_writeback_next_pc = wb_pc;
    i_alu_change_pc = alu; i_alu_next_pc = alu_pc;
    last_ack = 1'b0;
    if (ack_en && pend_addr.size() > 0 && (cyc - pend_cyc[0]) >= ack_delay) begin
      bus.i_ack_inst = 1'b1;
      bus.i_inst = rom(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
      last_ack = 1'b1;
    end else if (spur) begin
      bus.i_ack_inst = 1'b1;
      bus.i_inst = 32'hbad0_bad0;
    end else begin
      bus.i_ack_inst = 1'b0;
      bus.i_inst = $urandom;
    end
    @(negedge clk);
    last_stb = bus.o_stb_inst; last_addr = bus.o_inst_addr;
    last_ce = o_ce; last_pc = o_pc_ifid;
    if (prev_stall) begin
      chk("hold_ce", 32'(o_ce), 32'(prev_ce));
      chk("hold_pc", o_pc_ifid, prev_pc);
      chk("hold_inst", o_inst_ifid, prev_inst);
    end
    // Downstream takes the presented word in every non-stalled cycle (flush/redirect then discard it).
    if (!stall && o_ce && !stale) begin
      chk("deliver_pc", o_pc_ifid, exp_deliver);
      chk("deliver_inst", o_inst_ifid, rom(exp_deliver));
      exp_deliver += 32'd4;
      delivered++;
    end
    if (!stall) stale = 1'b0;
    if (bus.o_stb_inst) begin
      chk("issue_addr", bus.o_inst_addr, exp_fetch);
      chk("issue_in_redirect", 32'(wb | alu), 32'd0);
      exp_fetch += 32'd4;
      pend_addr.push_back(bus.o_inst_addr);
      pend_cyc.push_back(cyc);
      chk("outstanding_limit", 32'(pend_addr.size() <= MAX_OUTSTANDING), 32'd1);
    end
    if (wb | alu) begin
      tgt = wb ? wb_pc : alu_pc;
      tgt[1:0] = 2'b00;
      exp_fetch = tgt; exp_deliver = tgt;
      if (stall) stale = 1'b1;
    end
    prev_stall = stall; prev_ce = o_ce; prev_pc = o_pc_ifid; prev_inst = o_inst_ifid;
  endtask

  task automatic run(input bit stall, input bit ack_en);
    step(stall, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ack_en);
  endtask

  initial begin
    redir_vec_t tbl[6];
    bit         p;
    int         found_at;
    logic [31:0] got;
    int         d0;
    int         r;
    logic [31:0] t0, t1;

    tbl[0] = '{1'b0, 32'h0,    1'b1, 32'h100,       1'b0, 1'b0, 32'h100,       4};
    tbl[1] = '{1'b1, 32'h80,   1'b1, 32'h200,       1'b1, 1'b0, 32'h80,        3};
    tbl[2] = '{1'b1, 32'h1002, 1'b0, 32'h0,         1'b0, 1'b0, 32'h1000,      4};
    tbl[3] = '{1'b0, 32'h0,    1'b1, 32'hffff_ffff, 1'b1, 1'b0, 32'hffff_fffc, 3};
    tbl[4] = '{1'b1, 32'h40,   1'b1, 32'h44,        1'b0, 1'b1, 32'h40,        4};
    tbl[5] = '{1'b0, 32'h0,    1'b1, 32'h7,         1'b1, 1'b1, 32'h4,         3};

    do_reset();

    // Streaming after release: addresses 0,4,8.. from cycle 1, first o_ce in cycle 3.
    for (int i = 1; i <= 6; i++) begin
      run(1'b0, 1'b1);
      chk("stream_stb", 32'(last_stb), 32'd1);
      chk("stream_addr", last_addr, 32'(4 * (i - 1)));
      chk("stream_ce", 32'(last_ce), 32'(i >= 3));
      if (i >= 3) chk("stream_pc", last_pc, 32'(4 * (i - 3)));
    end

    // Six stalled cycles: queue fills, strobe stops, spurious acks with nothing outstanding ignored.
    for (int i = 1; i <= 6; i++) begin
      spur = (i >= 5);
      run(1'b1, 1'b1);
      if (i >= 4) chk("stall_stb", 32'(last_stb), 32'd0);
    end
    spur = 1'b0;
    for (int i = 0; i < 8; i++) run(1'b0, 1'b1);

    // Drain, then slow memory: with an empty queue o_ce follows each ack by one cycle.
    for (int i = 0; i < 8; i++) run(1'b0, 1'b0);
    ack_delay = 3;
    for (int i = 0; i < 14; i++) begin
      p = last_ack;
      run(1'b0, 1'b1);
      chk("bypass_latency", 32'(last_ce), 32'(p));
    end
    ack_delay = 1;

    // Redirect vectors: two reads in flight, optional ack in the redirect cycle, optional back-to-back redirect.
    foreach (tbl[n]) begin
      for (int i = 0; i < 3; i++) run(1'b0, 1'b0);
      if (tbl[n].dbl) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hdead_0000, 1'b0);
      step(1'b0, 1'b0, tbl[n].wb, tbl[n].wb_pc, tbl[n].alu, tbl[n].alu_pc, tbl[n].ack);
      found_at = 0; got = '0;
      for (int k = 1; k <= 12; k++) begin
        run(1'b0, 1'b1);
        if (last_ce && found_at == 0) begin
          found_at = k; got = last_pc;
        end
      end
      chk("redirect_first_pc", got, tbl[n].exp_pc);
      chk("redirect_gap", 32'(found_at), 32'(tbl[n].exp_gap));
    end

    // Reset in the middle of a stalled, full queue; fetch restarts at PC_RESET.
    for (int i = 0; i < 6; i++) run(1'b1, 1'b1);
    do_reset();
    run(1'b0, 1'b1);
    chk("restart_stb", 32'(last_stb), 32'd1);
    chk("restart_addr", last_addr, PC_RESET);
    for (int i = 0; i < 4; i++) run(1'b0, 1'b1);

    // Random traffic against the stream model.
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 19));
      t0 = ($urandom_range(0, 7) == 0) ? (32'hffff_fff0 | 32'($urandom_range(0, 15))) : $urandom;
      t1 = $urandom;
      ack_delay = int'($urandom_range(1, 3));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           (r == 0) || (r == 3), t0, (r == 1) || (r == 2) || (r == 3), t1,
           $urandom_range(0, 3) != 0);
    end
    chk("liveness", 32'((delivered - d0) >= 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
